// File: rtl/id_issue_stage.sv
// RV32I-subset decode/issue stage: combinational decode of the fetched word, registered
// bundle to execute through a main register plus one skid entry so in_ready stays registered.
module id_issue_stage #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_instr,
   input  logic [31:0]      in_pc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [31:0]      out_pc,
   output logic [1:0]       ALUOp,
   output logic [2:0]       funct3,
   output logic             funct7,
   output logic             ALUSrc,
   output logic [31:0]      imm32,
   output logic [4:0]       rs1,
   output logic [4:0]       rs2,
   output logic [4:0]       rd,
   output logic             RegWrite,
   output logic             MemRead,
   output logic             MemWrite,
   output logic             MemtoReg,
   output logic             Branch,
   output logic             illegal,
   output logic [CNT_W-1:0] issue_count
);

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } state_t;

   typedef struct packed {
      logic [31:0] pc;
      logic [1:0]  alu_op;
      logic [2:0]  f3;
      logic        f7;
      logic        alu_src;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic        reg_write;
      logic        mem_read;
      logic        mem_write;
      logic        mem_to_reg;
      logic        branch;
      logic        illegal;
   } bundle_t;

   state_t     state_r;
   state_t     state_next_s;
   bundle_t    dec_s;
   bundle_t    main_r;
   bundle_t    skid_r;
   logic       acc_s;
   logic       con_s;
   logic       load_main_s;
   logic       load_skid_s;
   logic       skid_to_main_s;
   logic [6:0] opcode_s;
   logic [6:0] f7_full_s;
   logic [2:0] f3_s;

   assign in_ready  = (state_r != TWO);
   assign out_valid = (state_r != EMPTY);
   assign acc_s     = in_valid && in_ready;
   assign con_s     = out_valid && out_ready;

   assign opcode_s  = in_instr[6:0];
   assign f3_s      = in_instr[14:12];
   assign f7_full_s = in_instr[31:25];

   // Decode of the offered instruction; unsupported encodings flow through with controls cleared
   always_comb begin
      dec_s            = '0;
      dec_s.pc         = in_pc;
      dec_s.f3         = f3_s;
      dec_s.rs1        = in_instr[19:15];
      dec_s.rs2        = in_instr[24:20];
      dec_s.rd         = in_instr[11:7];
      dec_s.illegal    = 1'b1;
      case (opcode_s)
         7'b0110011: begin
            if (((f3_s == 3'b000) && ((f7_full_s == 7'b0000000) || (f7_full_s == 7'b0100000))) ||
                (((f3_s == 3'b110) || (f3_s == 3'b111)) && (f7_full_s == 7'b0000000))) begin
               dec_s.illegal   = 1'b0;
               dec_s.alu_op    = 2'b10;
               dec_s.f7        = in_instr[30];
               dec_s.reg_write = 1'b1;
            end else begin
               dec_s.illegal   = 1'b1;
            end
         end
         7'b0010011: begin
            if ((f3_s == 3'b000) || (f3_s == 3'b110) || (f3_s == 3'b111)) begin
               dec_s.illegal   = 1'b0;
               dec_s.alu_op    = 2'b10;
               dec_s.alu_src   = 1'b1;
               dec_s.reg_write = 1'b1;
               dec_s.imm       = {{20{in_instr[31]}}, in_instr[31:20]};
            end else begin
               dec_s.illegal   = 1'b1;
            end
         end
         7'b0000011: begin
            if (f3_s == 3'b010) begin
               dec_s.illegal    = 1'b0;
               dec_s.alu_src    = 1'b1;
               dec_s.mem_read   = 1'b1;
               dec_s.mem_to_reg = 1'b1;
               dec_s.reg_write  = 1'b1;
               dec_s.imm        = {{20{in_instr[31]}}, in_instr[31:20]};
            end else begin
               dec_s.illegal    = 1'b1;
            end
         end
         7'b0100011: begin
            if (f3_s == 3'b010) begin
               dec_s.illegal   = 1'b0;
               dec_s.alu_src   = 1'b1;
               dec_s.mem_write = 1'b1;
               dec_s.imm       = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end else begin
               dec_s.illegal   = 1'b1;
            end
         end
         7'b1100011: begin
            if (f3_s == 3'b000) begin
               dec_s.illegal = 1'b0;
               dec_s.alu_op  = 2'b01;
               dec_s.branch  = 1'b1;
               dec_s.imm     = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                                in_instr[30:25], in_instr[11:8], 1'b0};
            end else begin
               dec_s.illegal = 1'b1;
            end
         end
         default: begin
            dec_s.illegal = 1'b1;
         end
      endcase
   end

   // Occupancy state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= EMPTY;
      end else begin
         state_r <= state_next_s;
      end
   end

   // Next occupancy; flush wins over any same-cycle acceptance
   always_comb begin
      state_next_s = state_r;
      if (flush) begin
         state_next_s = EMPTY;
      end else begin
         case (state_r)
            EMPTY:   state_next_s = acc_s ? ONE : EMPTY;
            ONE: begin
               if (acc_s && !con_s) begin
                  state_next_s = TWO;
               end else if (!acc_s && con_s) begin
                  state_next_s = EMPTY;
               end else begin
                  state_next_s = ONE;
               end
            end
            TWO:     state_next_s = con_s ? ONE : TWO;
            default: state_next_s = EMPTY;
         endcase
      end
   end

   // Register load enables derived from state and handshakes
   always_comb begin
      load_main_s    = 1'b0;
      load_skid_s    = 1'b0;
      skid_to_main_s = 1'b0;
      if (flush) begin
         load_main_s    = 1'b0;
      end else begin
         load_main_s    = acc_s && ((state_r == EMPTY) || ((state_r == ONE) && con_s));
         load_skid_s    = acc_s && (state_r == ONE) && !con_s;
         skid_to_main_s = (state_r == TWO) && con_s;
      end
   end

   // Main (output) and skid bundle registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         main_r <= '0;
         skid_r <= '0;
      end else begin
         if (load_main_s) begin
            main_r <= dec_s;
         end else if (skid_to_main_s) begin
            main_r <= skid_r;
         end else begin
            main_r <= main_r;
         end
         if (load_skid_s) begin
            skid_r <= dec_s;
         end else begin
            skid_r <= skid_r;
         end
      end
   end

   // Consumed-bundle counter, wraps freely; a flush cycle still counts its consumption
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         issue_count <= '0;
      end else if (con_s) begin
         issue_count <= issue_count + {{(CNT_W-1){1'b0}}, 1'b1};
      end else begin
         issue_count <= issue_count;
      end
   end

   assign out_pc   = main_r.pc;
   assign ALUOp    = main_r.alu_op;
   assign funct3   = main_r.f3;
   assign funct7   = main_r.f7;
   assign ALUSrc   = main_r.alu_src;
   assign imm32    = main_r.imm;
   assign rs1      = main_r.rs1;
   assign rs2      = main_r.rs2;
   assign rd       = main_r.rd;
   assign RegWrite = main_r.reg_write;
   assign MemRead  = main_r.mem_read;
   assign MemWrite = main_r.mem_write;
   assign MemtoReg = main_r.mem_to_reg;
   assign Branch   = main_r.branch;
   assign illegal  = main_r.illegal;

endmodule

// File: tb/tb_id_issue_stage.sv
// Directed bench for id_issue_stage: decode table, backpressure/skid ordering, flush,
// counter wrap and asynchronous reset.
module tb_id_issue_stage;

   localparam int CNT_W = 4;

   logic             clk;
   logic             rst_n;
   logic             flush;
   logic             in_valid;
   logic             in_ready;
   logic [31:0]      in_instr;
   logic [31:0]      in_pc;
   logic             out_valid;
   logic             out_ready;
   logic [31:0]      out_pc;
   logic [1:0]       ALUOp;
   logic [2:0]       funct3;
   logic             funct7;
   logic             ALUSrc;
   logic [31:0]      imm32;
   logic [4:0]       rs1;
   logic [4:0]       rs2;
   logic [4:0]       rd;
   logic             RegWrite;
   logic             MemRead;
   logic             MemWrite;
   logic             MemtoReg;
   logic             Branch;
   logic             illegal;
   logic [CNT_W-1:0] issue_count;

   logic [12:0] ctl;
   logic [14:0] regs;
   int          total_cnt;
   int          pass_cnt;

   assign ctl  = {ALUOp, funct3, funct7, ALUSrc, RegWrite, MemRead, MemWrite, MemtoReg, Branch, illegal};
   assign regs = {rs1, rs2, rd};

   // {ALUOp,funct3,funct7,ALUSrc,RegWrite,MemRead,MemWrite,MemtoReg,Branch,illegal}
   localparam logic [31:0] D_INSTR [9] = '{32'h002081B3, 32'h402081B3, 32'hFFF00293, 32'h40000093,
                                           32'h0020A423, 32'h0080A183, 32'hFE208EE3, 32'h00000000,
                                           32'h002091B3};
   localparam logic [12:0] D_CTL [9]   = '{13'b10_000_0_0_1_00000, 13'b10_000_1_0_1_00000,
                                           13'b10_000_0_1_1_00000, 13'b10_000_0_1_1_00000,
                                           13'b00_010_0_1_0_01000, 13'b00_010_0_1_1_10100,
                                           13'b01_000_0_0_0_00010, 13'b00_000_0_0_0_00001,
                                           13'b00_001_0_0_0_00001};
   localparam logic [31:0] D_IMM [9]   = '{32'h0, 32'h0, 32'hFFFFFFFF, 32'h00000400, 32'h00000008,
                                           32'h00000008, 32'hFFFFFFFC, 32'h0, 32'h0};
   localparam logic [14:0] D_REGS [9]  = '{{5'd1, 5'd2, 5'd3}, {5'd1, 5'd2, 5'd3}, {5'd0, 5'd31, 5'd5},
                                           {5'd0, 5'd0, 5'd1}, {5'd1, 5'd2, 5'd8}, {5'd1, 5'd8, 5'd3},
                                           {5'd1, 5'd2, 5'd29}, {5'd0, 5'd0, 5'd0}, {5'd1, 5'd2, 5'd3}};

   id_issue_stage #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
      .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
      .ALUOp(ALUOp), .funct3(funct3), .funct7(funct7), .ALUSrc(ALUSrc), .imm32(imm32),
      .rs1(rs1), .rs2(rs2), .rd(rd),
      .RegWrite(RegWrite), .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
      .Branch(Branch), .illegal(illegal), .issue_count(issue_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      in_instr = 32'h0; in_pc = 32'h0;
      #12;
      total_cnt++;
      if ({out_valid, out_pc, ctl, imm32, regs, issue_count} !== '0)
         $display("FAIL reset_outputs: got valid=%b pc=%h ctl=%b imm=%h cnt=%0d want all 0",
                  out_valid, out_pc, ctl, imm32, issue_count);
      else pass_cnt++;
      rst_n = 1'b1;
      tick();
      total_cnt++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0)
         $display("FAIL reset_release: got in_ready=%b out_valid=%b want 1 0", in_ready, out_valid);
      else pass_cnt++;
   endtask

   task automatic test_decode();
      out_ready = 1'b1;
      for (int i = 0; i < 9; i++) begin
         in_valid = 1'b1; in_instr = D_INSTR[i]; in_pc = 32'h1000 + 32'(4 * i);
         tick();
         in_valid = 1'b0;
         total_cnt++;
         if (out_valid !== 1'b1 || out_pc !== 32'h1000 + 32'(4 * i))
            $display("FAIL dec%0d_valid_pc: got valid=%b pc=%h want 1 %h", i, out_valid, out_pc,
                     32'h1000 + 32'(4 * i));
         else pass_cnt++;
         total_cnt++;
         if (ctl !== D_CTL[i]) $display("FAIL dec%0d_ctl: got %b want %b", i, ctl, D_CTL[i]);
         else pass_cnt++;
         total_cnt++;
         if (imm32 !== D_IMM[i]) $display("FAIL dec%0d_imm: got %h want %h", i, imm32, D_IMM[i]);
         else pass_cnt++;
         total_cnt++;
         if (regs !== D_REGS[i]) $display("FAIL dec%0d_regs: got %h want %h", i, regs, D_REGS[i]);
         else pass_cnt++;
      end
      tick();
      total_cnt++;
      if (out_valid !== 1'b0 || issue_count !== 4'd9)
         $display("FAIL decode_drain: got valid=%b cnt=%0d want 0 9", out_valid, issue_count);
      else pass_cnt++;
   endtask

   task automatic test_back_to_back();
      test_reset();
      out_ready = 1'b0;
      in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h100;
      tick();
      total_cnt++;
      if (in_ready !== 1'b1 || out_valid !== 1'b1 || out_pc !== 32'h100)
         $display("FAIL bp_first: got rdy=%b valid=%b pc=%h want 1 1 100", in_ready, out_valid, out_pc);
      else pass_cnt++;
      in_pc = 32'h104; in_instr = 32'h402081B3;
      tick();
      total_cnt++;
      if (in_ready !== 1'b0 || out_pc !== 32'h100)
         $display("FAIL bp_second: got rdy=%b pc=%h want 0 100", in_ready, out_pc);
      else pass_cnt++;
      in_pc = 32'h108; in_instr = 32'hFE208EE3;
      tick();
      total_cnt++;
      if (in_ready !== 1'b0 || out_pc !== 32'h100 || funct7 !== 1'b0 || issue_count !== 4'd0)
         $display("FAIL bp_hold: got rdy=%b pc=%h f7=%b cnt=%0d want 0 100 0 0",
                  in_ready, out_pc, funct7, issue_count);
      else pass_cnt++;
      out_ready = 1'b1;
      tick();
      total_cnt++;
      if (out_pc !== 32'h104 || funct7 !== 1'b1 || in_ready !== 1'b1 || issue_count !== 4'd1)
         $display("FAIL bp_skid_out: got pc=%h f7=%b rdy=%b cnt=%0d want 104 1 1 1",
                  out_pc, funct7, in_ready, issue_count);
      else pass_cnt++;
      tick();
      in_valid = 1'b0;
      total_cnt++;
      if (out_valid !== 1'b1 || out_pc !== 32'h108 || Branch !== 1'b1 || issue_count !== 4'd2)
         $display("FAIL bp_third: got valid=%b pc=%h br=%b cnt=%0d want 1 108 1 2",
                  out_valid, out_pc, Branch, issue_count);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (out_valid !== 1'b0 || issue_count !== 4'd3)
         $display("FAIL bp_count: got valid=%b cnt=%0d want 0 3", out_valid, issue_count);
      else pass_cnt++;
   endtask

   task automatic test_flush();
      test_reset();
      out_ready = 1'b0;
      in_valid = 1'b1; in_instr = 32'h002081B3; in_pc = 32'h180;
      tick();
      in_pc = 32'h184;
      tick();
      total_cnt++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1)
         $display("FAIL fl_two: got rdy=%b valid=%b want 0 1", in_ready, out_valid);
      else pass_cnt++;
      flush = 1'b1; in_pc = 32'h200;
      tick();
      total_cnt++;
      if (out_valid !== 1'b0 || in_ready !== 1'b1)
         $display("FAIL fl_two_drop: got valid=%b rdy=%b want 0 1", out_valid, in_ready);
      else pass_cnt++;
      // flush in EMPTY with an acceptable offer must not capture it
      in_pc = 32'h300;
      tick();
      flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      tick();
      total_cnt++;
      if (out_valid !== 1'b0 || issue_count !== 4'd0)
         $display("FAIL fl_no_capture: got valid=%b cnt=%0d want 0 0", out_valid, issue_count);
      else pass_cnt++;
      in_valid = 1'b1; in_pc = 32'h304;
      tick();
      in_valid = 1'b0;
      total_cnt++;
      if (out_valid !== 1'b1 || out_pc !== 32'h304)
         $display("FAIL fl_resume: got valid=%b pc=%h want 1 304", out_valid, out_pc);
      else pass_cnt++;
      flush = 1'b1;
      tick();
      flush = 1'b0;
      total_cnt++;
      if (out_valid !== 1'b0 || issue_count !== 4'd1)
         $display("FAIL fl_counts_con: got valid=%b cnt=%0d want 0 1", out_valid, issue_count);
      else pass_cnt++;
   endtask

   task automatic test_async_reset();
      out_ready = 1'b0;
      in_valid = 1'b1; in_instr = 32'hFE208EE3; in_pc = 32'h400;
      tick();
      tick();
      in_valid = 1'b0;
      #2 rst_n = 1'b0;
      #1;
      total_cnt++;
      if ({out_valid, out_pc, ctl, imm32, regs, issue_count} !== '0)
         $display("FAIL async_reset: got valid=%b pc=%h ctl=%b imm=%h cnt=%0d want all 0",
                  out_valid, out_pc, ctl, imm32, issue_count);
      else pass_cnt++;
      #2 rst_n = 1'b1;
      tick();
      total_cnt++;
      if (in_ready !== 1'b1 || out_valid !== 1'b0)
         $display("FAIL async_release: got rdy=%b valid=%b want 1 0", in_ready, out_valid);
      else pass_cnt++;
   endtask

   task automatic test_count_wrap();
      test_reset();
      out_ready = 1'b1;
      in_valid = 1'b1; in_instr = 32'hFFF00293; in_pc = 32'h500;
      repeat (16) tick();
      total_cnt++;
      if (issue_count !== 4'd15) $display("FAIL cnt_pre_wrap: got %0d want 15", issue_count);
      else pass_cnt++;
      tick();
      total_cnt++;
      if (issue_count !== 4'd0 || out_valid !== 1'b1)
         $display("FAIL cnt_wrap: got cnt=%0d valid=%b want 0 1", issue_count, out_valid);
      else pass_cnt++;
      in_valid = 1'b0;
      tick();
      total_cnt++;
      if (issue_count !== 4'd1) $display("FAIL cnt_post_wrap: got %0d want 1", issue_count);
      else pass_cnt++;
   endtask

   initial begin
      total_cnt = 0;
      pass_cnt  = 0;
      test_reset();
      test_decode();
      test_back_to_back();
      test_flush();
      test_async_reset();
      test_count_wrap();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule

// File: doc/id_issue_stage.md
Name: id_issue_stage

Overview:
- Decode/issue stage that drives the execute stage's control inputs: ALUOp, funct3, funct7, ALUSrc, imm32, plus the register, memory and writeback controls for the RV32I subset (add, sub, and, or, addi/andi/ori, lw, sw, beq).
- Sits between instruction fetch and execute.
- Registered output with valid/ready handshakes on both sides and a 2-entry skid buffer, giving full throughput and a registered in_ready.

Parameters:
- CNT_W, 16, width of the issued-instruction counter.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  synchronous; discard all buffered instructions
- in_valid  in  1  fetch offers in_instr/in_pc
- in_ready  out  1  stage can accept this cycle
- in_instr  in  32  raw instruction
- in_pc  in  32  instruction address
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute consumes bundle
- out_pc  out  32  pc of bundle
- ALUOp  out  2  00 load/store add, 01 branch sub, 10 funct-decoded
- funct3  out  3  instr[14:12]
- funct7  out  1  instr[30] for R-type, forced 0 otherwise
- ALUSrc  out  1  1 selects imm32 as operand2
- imm32  out  32  sign-extended immediate (I/S/B format)
- rs1, rs2, rd  out  5 each  register indices
- RegWrite, MemRead, MemWrite, MemtoReg, Branch  out  1 each  controls
- illegal  out  1  instruction outside the supported subset
- issue_count  out  CNT_W  bundles consumed since reset

Behaviour:
- Reset: all outputs 0, state EMPTY, in_ready 1 after reset release, issue_count 0.
- Decode is combinational on in_instr. The result is written into the main register (or the skid register) on acceptance (in_valid && in_ready).
- Latency is 1 cycle: an instruction accepted at edge N presents out_valid at N+1 if main was empty or consumed.
- States:
  - EMPTY: no entries.
  - ONE: main full.
  - TWO: main and skid full.
- in_ready = (state != TWO). It is driven purely from the register state.
- Transitions, where acc = in_valid && in_ready and con = out_valid && out_ready:
  - EMPTY: acc -> ONE.
  - ONE: acc && !con -> TWO (new entry into skid); !acc && con -> EMPTY; acc && con -> ONE (main reloaded).
  - TWO: con -> ONE (skid moves to main). No acceptance is possible in TWO.
- Order is strictly FIFO. No duplication or loss.
- Output bundle is held stable while out_valid && !out_ready.
- flush: next state is EMPTY and both entries are dropped. flush overrides a same-cycle acc, so the offered instruction is not captured. issue_count still counts a same-cycle con.
- Decode by opcode:
  - 0110011 R-type: ALUOp 10, ALUSrc 0, RegWrite 1, funct7 = instr[30]. Legal cases are funct3 000 with instr[31:25] 0000000 or 0100000, and funct3 110/111 with 0000000.
  - 0010011 I-ALU: ALUOp 10, ALUSrc 1, RegWrite 1, funct7 0 (addi must never select sub), I-imm. Legal funct3 is 000/110/111.
  - 0000011 lw: funct3 must be 010. ALUOp 00, ALUSrc 1, MemRead 1, MemtoReg 1, RegWrite 1, I-imm.
  - 0100011 sw: funct3 must be 010. ALUOp 00, ALUSrc 1, MemWrite 1, S-imm.
  - 1100011 beq: funct3 must be 000. ALUOp 01, ALUSrc 0, Branch 1, B-imm (bit0 = 0).
- Illegal/other: illegal 1. RegWrite, MemRead, MemWrite, MemtoReg, Branch and ALUSrc are all 0, ALUOp 00, imm32 0. The bundle still flows through the handshake.
- rs1/rs2/rd are always the raw instruction fields. funct3 is always instr[14:12].
- issue_count increments on con and wraps modulo 2^CNT_W without saturation.
- Reset asserted mid-operation clears everything immediately, including the skid entry.

Test Plan:
- Issue 0x002081B3 (add x3,x1,x2) with out_ready=1 -> next cycle out_valid=1, ALUOp=10, funct3=000, funct7=0, ALUSrc=0, rs1=1, rs2=2, rd=3, RegWrite=1, illegal=0. Then issue 0x402081B3 -> same fields except funct7=1.
- Issue 0xFFF00293 (addi x5,x0,-1) -> imm32=0xFFFFFFFF, ALUSrc=1, funct7=0, rd=5. Issue 0x0020A423 (sw x2,8(x1)) -> imm32=0x00000008, MemWrite=1, RegWrite=0, ALUOp=00.
- Issue 0xFE208EE3 (beq x1,x2,-4) -> ALUOp=01, Branch=1, imm32=0xFFFFFFFC, ALUSrc=0. Issue 0x00000000 -> illegal=1, all controls 0.
- Hold out_ready=0 and offer 3 instructions back-to-back -> first 2 accepted, in_ready=0 from the cycle after the 2nd. Release out_ready -> outputs appear in order, 3rd accepted one cycle after the first consumption, issue_count=3 at the end.
- In state TWO, assert flush for 1 cycle with in_valid=1 -> out_valid=0 next cycle, in_ready=1, offered instruction not captured. Assert rst_n=0 asynchronously mid-stream -> all outputs 0 and issue_count=0 before the next clock edge.
